// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state encoding and default HC-SR04 timing at 50 MHz.
// Combinational constants only; no latency or backpressure.
package sonar_pkg;

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    ESPERA_TRIGGER = 3'd1,
    MEDE_TRIGGER   = 3'd2,
    ATRASO         = 3'd3,
    ECO            = 3'd4,
    PAUSA          = 3'd5
  } estado_t;

  localparam int PADRAO_TRIGGER_MIN = 500;
  localparam int PADRAO_ATRASO      = 20_000;
  localparam int PADRAO_POR_CM      = 2941;
  localparam int PADRAO_DIST_MAX    = 400;
  localparam int PADRAO_TIMEOUT     = 1_900_000;
  localparam int PADRAO_PAUSA       = 500_000;

  // Wide enough for 400 cm * 2941 and for the 38 ms timeout.
  localparam int LARG_CONT = 22;

  // The sensor answers 0 cm as if it were 1 cm.
  function automatic logic [8:0] dist_efetiva(input logic [8:0] d);
    return (d == 9'd0) ? 9'd1 : d;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M counter with synchronous clear and count enable; fim is high while q == M-1.
// Registered count, one cycle per step; no backpressure.
module contador_m #(
  parameter int M = 10,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  logic [N-1:0] q_q, q_d;

  assign fim = (q_q == N'(M - 1));
  assign q   = q_q;

  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta) begin
      q_d = fim ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/sensor_ultrassonico_uc.sv
// Control FSM of the HC-SR04 emulator: sequences trigger check, delay, echo and dead time.
// echo/ocupado are registered from the next state, so they change on the same edge as the state; no backpressure.
module sensor_ultrassonico_uc
  import sonar_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic       largura_ok,
  input  logic       atraso_fim,
  input  logic       eco_fim,
  input  logic       pausa_fim,
  output logic       inicia_largura,
  output logic       conta_largura,
  output logic       carrega,
  output logic       echo,
  output logic       ocupado,
  output logic [2:0] estado
);

  estado_t estado_q, estado_d;
  logic    echo_q, echo_d;
  logic    ocupado_q, ocupado_d;

  always_comb begin
    estado_d       = estado_q;
    inicia_largura = 1'b0;
    conta_largura  = 1'b0;
    carrega        = 1'b0;
    case (estado_q)
      INICIAL:        estado_d = ESPERA_TRIGGER;
      ESPERA_TRIGGER: begin
        if (trigger) begin
          inicia_largura = 1'b1;
          estado_d       = MEDE_TRIGGER;
        end
      end
      MEDE_TRIGGER: begin
        if (trigger) begin
          conta_largura = 1'b1;
        end else if (largura_ok) begin
          carrega  = 1'b1;
          estado_d = ATRASO;
        end else begin
          estado_d = ESPERA_TRIGGER;
        end
      end
      ATRASO:  if (atraso_fim) estado_d = ECO;
      ECO:     if (eco_fim) estado_d = PAUSA;
      // A trigger still high here is left alone until it drops, so it is never measured mid-pulse.
      PAUSA:   if (pausa_fim && !trigger) estado_d = ESPERA_TRIGGER;
      default: estado_d = INICIAL;
    endcase
    echo_d    = (estado_d == ECO);
    ocupado_d = (estado_d == ATRASO) || (estado_d == ECO) || (estado_d == PAUSA);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      echo_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      echo_q    <= echo_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign echo    = echo_q;
  assign ocupado = ocupado_q;
  assign estado  = estado_q;

endmodule

// File: rtl/sensor_ultrassonico_emulador.sv
// HC-SR04 responder: validates trigger width, waits the burst delay, then echoes max(d,1)*CICLOS_POR_CM cycles (or timeout).
// Echo rises CICLOS_ATRASO cycles after trigger is first sampled low; trigger is ignored while busy, no backpressure.
module sensor_ultrassonico_emulador
  import sonar_pkg::*;
#(
  parameter int CICLOS_TRIGGER_MIN = PADRAO_TRIGGER_MIN,
  parameter int CICLOS_ATRASO      = PADRAO_ATRASO,
  parameter int CICLOS_POR_CM      = PADRAO_POR_CM,
  parameter int DIST_MAX           = PADRAO_DIST_MAX,
  parameter int CICLOS_TIMEOUT     = PADRAO_TIMEOUT,
  parameter int CICLOS_PAUSA       = PADRAO_PAUSA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  localparam int LT = $clog2(CICLOS_TRIGGER_MIN + 1);

  estado_t estado;
  logic inicia_largura, conta_largura, carrega;
  logic largura_ok, atraso_fim, sub_fim, eco_fim, pausa_fim;
  logic [LARG_CONT-1:0] unused_q_atraso, unused_q_sub, unused_q_pausa;

  logic [LT-1:0]        larg_q, larg_d;
  logic [8:0]           dist_q, dist_d;
  logic                 fora_q, fora_d;
  logic [LARG_CONT-1:0] cm_q, cm_d;
  logic [LARG_CONT-1:0] alvo_cm;

  assign estado = estado_t'(db_estado);

  sensor_ultrassonico_uc u_uc (
    .clock          (clock),
    .reset          (reset),
    .trigger        (trigger),
    .largura_ok     (largura_ok),
    .atraso_fim     (atraso_fim),
    .eco_fim        (eco_fim),
    .pausa_fim      (pausa_fim),
    .inicia_largura (inicia_largura),
    .conta_largura  (conta_largura),
    .carrega        (carrega),
    .echo           (echo),
    .ocupado        (ocupado),
    .estado         (db_estado)
  );

  contador_m #(.M(CICLOS_ATRASO), .N(LARG_CONT)) u_cont_atraso (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ATRASO),
    .conta (estado == ATRASO),
    .q     (unused_q_atraso),
    .fim   (atraso_fim)
  );

  contador_m #(.M(CICLOS_POR_CM), .N(LARG_CONT)) u_cont_sub (
    .clock (clock),
    .reset (reset),
    .zera  (estado != ECO),
    .conta ((estado == ECO) && !fora_q),
    .q     (unused_q_sub),
    .fim   (sub_fim)
  );

  // Held at its last value once done, so PAUSA can wait for trigger to drop.
  contador_m #(.M(CICLOS_PAUSA), .N(LARG_CONT)) u_cont_pausa (
    .clock (clock),
    .reset (reset),
    .zera  (estado != PAUSA),
    .conta ((estado == PAUSA) && !pausa_fim),
    .q     (unused_q_pausa),
    .fim   (pausa_fim)
  );

  assign largura_ok = (larg_q >= LT'(CICLOS_TRIGGER_MIN));

  // Out of range the cm-counter runs every cycle as a flat timeout counter.
  assign alvo_cm = fora_q ? LARG_CONT'(CICLOS_TIMEOUT - 1)
                          : {{(LARG_CONT-9){1'b0}}, dist_efetiva(dist_q)} - LARG_CONT'(1);
  assign eco_fim = (estado == ECO) && (cm_q == alvo_cm) && (fora_q || sub_fim);

  always_comb begin
    larg_d = larg_q;
    if (inicia_largura) begin
      larg_d = LT'(1);
    end else if (conta_largura && (larg_q != LT'(CICLOS_TRIGGER_MIN))) begin
      larg_d = larg_q + LT'(1);
    end

    dist_d = dist_q;
    fora_d = fora_q;
    if (carrega) begin
      dist_d = distancia;
      fora_d = (distancia > 9'(DIST_MAX));
    end

    cm_d = cm_q;
    if (estado != ECO) begin
      cm_d = '0;
    end else if (fora_q || sub_fim) begin
      cm_d = cm_q + LARG_CONT'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      larg_q <= '0;
      dist_q <= '0;
      fora_q <= 1'b0;
      cm_q   <= '0;
    end else begin
      larg_q <= larg_d;
      dist_q <= dist_d;
      fora_q <= fora_d;
      cm_q   <= cm_d;
    end
  end

endmodule

// File: tb/tb_sensor_ultrassonico_emulador.sv
// Bench for the HC-SR04 emulator with shortened timing constants.
// Expected timing comes from a small arithmetic model of the sensor rules.
module tb_sensor_ultrassonico_emulador;

  localparam int P_MIN    = 5;
  localparam int P_ATRASO = 20;
  localparam int P_CM     = 3;
  localparam int P_DMAX   = 40;
  localparam int P_TO     = 150;
  localparam int P_PAUSA  = 50;
  localparam int LIM      = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia = 9'd0;
  logic       echo;
  logic       ocupado;
  logic [2:0] db_estado;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  sensor_ultrassonico_emulador #(
    .CICLOS_TRIGGER_MIN (P_MIN),
    .CICLOS_ATRASO      (P_ATRASO),
    .CICLOS_POR_CM      (P_CM),
    .DIST_MAX           (P_DMAX),
    .CICLOS_TIMEOUT     (P_TO),
    .CICLOS_PAUSA       (P_PAUSA)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .distancia (distancia),
    .echo      (echo),
    .ocupado   (ocupado),
    .db_estado (db_estado)
  );

  function automatic int modelo_largura(input int d);
    if (d > P_DMAX) return P_TO;
    if (d == 0) return P_CM;
    return d * P_CM;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulso(input int w);
    trigger = 1'b1;
    repeat (w) tick();
    trigger = 1'b0;
  endtask

  // Called right after trigger is driven low. Modes: 1 = change distancia mid-echo,
  // 2 = extra trigger pulses during delay and echo, 3 = trigger held across pause exit.
  task automatic observe(input int modo, output int atraso, output int largura,
                         output int pausa, output int oc_ini, output int st_atr,
                         output int st_eco, output int st_pau, output int estourou);
    estourou = 0; atraso = 0; largura = 0; pausa = 0;
    tick();
    oc_ini = int'(ocupado);
    st_atr = int'(db_estado);
    while (echo !== 1'b1 && atraso < LIM) begin
      tick();
      atraso++;
      if (modo == 2 && atraso == 2) trigger = 1'b1;
      if (modo == 2 && atraso == 3 + P_MIN) trigger = 1'b0;
    end
    if (atraso >= LIM) estourou = 1;
    st_eco = int'(db_estado);
    while (echo === 1'b1 && largura < LIM) begin
      tick();
      largura++;
      if (modo == 1 && largura == 5) distancia = 9'd300;
      if (modo == 2 && largura == 3) trigger = 1'b1;
      if (modo == 2 && largura == 5 + P_MIN) trigger = 1'b0;
    end
    if (largura >= LIM) estourou = 1;
    trigger = (modo == 2) ? 1'b0 : trigger;
    st_pau = int'(db_estado);
    while (ocupado === 1'b1 && pausa < LIM) begin
      tick();
      pausa++;
      if (modo == 3 && pausa == P_PAUSA - 10) trigger = 1'b1;
      if (modo == 3 && pausa == P_PAUSA + 7) trigger = 1'b0;
    end
    if (pausa >= LIM) estourou = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (echo !== 1'b0) $display("FAIL reset_echo: got %0b expected 0", echo); else n_pass++;
    n_checks++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %0b expected 0", ocupado); else n_pass++;
    n_checks++; if (db_estado !== 3'd0) $display("FAIL reset_estado: got %0d expected 0", db_estado); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (db_estado !== 3'd1) $display("FAIL inicial_to_espera: got %0d expected 1", db_estado); else n_pass++;
  endtask

  task automatic test_basic();
    int a, l, p, oc, sa, se, sp, to;
    distancia = 9'd10;
    pulso(P_MIN + 5);
    observe(0, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (to != 0) $display("FAIL basic_timeout: got %0d expected 0", to); else n_pass++;
    n_checks++; if (oc != 1) $display("FAIL basic_ocupado_rise: got %0d expected 1", oc); else n_pass++;
    n_checks++; if (sa != 3) $display("FAIL basic_state_atraso: got %0d expected 3", sa); else n_pass++;
    n_checks++; if (a != P_ATRASO) $display("FAIL basic_delay: got %0d expected %0d", a, P_ATRASO); else n_pass++;
    n_checks++; if (se != 4) $display("FAIL basic_state_eco: got %0d expected 4", se); else n_pass++;
    n_checks++; if (l != modelo_largura(10)) $display("FAIL basic_width: got %0d expected %0d", l, modelo_largura(10)); else n_pass++;
    n_checks++; if (sp != 5) $display("FAIL basic_state_pausa: got %0d expected 5", sp); else n_pass++;
    n_checks++; if (p != P_PAUSA) $display("FAIL basic_pause: got %0d expected %0d", p, P_PAUSA); else n_pass++;
    n_checks++; if (db_estado !== 3'd1) $display("FAIL basic_back_to_espera: got %0d expected 1", db_estado); else n_pass++;
  endtask

  task automatic test_trigger_width();
    int a, l, p, oc, sa, se, sp, to;
    int viol;
    distancia = 9'd7;
    pulso(P_MIN);
    observe(0, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (l != modelo_largura(7)) $display("FAIL minwidth_width: got %0d expected %0d", l, modelo_largura(7)); else n_pass++;
    pulso(P_MIN - 1);
    viol = 0;
    for (int i = 0; i < P_ATRASO + P_TO + 20; i++) begin
      tick();
      if (echo !== 1'b0 || ocupado !== 1'b0) viol++;
    end
    n_checks++; if (viol != 0) $display("FAIL short_trigger_ignored: got %0d busy cycles expected 0", viol); else n_pass++;
    n_checks++; if (db_estado !== 3'd1) $display("FAIL short_trigger_state: got %0d expected 1", db_estado); else n_pass++;
    distancia = 9'd12;
    pulso(P_MIN + 2);
    observe(0, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (a != P_ATRASO) $display("FAIL after_short_delay: got %0d expected %0d", a, P_ATRASO); else n_pass++;
    n_checks++; if (l != modelo_largura(12)) $display("FAIL after_short_width: got %0d expected %0d", l, modelo_largura(12)); else n_pass++;
  endtask

  task automatic test_boundaries();
    int a, l, p, oc, sa, se, sp, to;
    int dists[6] = '{0, 1, P_DMAX, P_DMAX + 1, 450, 511};
    for (int i = 0; i < 6; i++) begin
      distancia = 9'(dists[i]);
      pulso(P_MIN + 1);
      observe(0, a, l, p, oc, sa, se, sp, to);
      n_checks++;
      if (l != modelo_largura(dists[i]) || to != 0)
        $display("FAIL boundary_width d=%0d: got %0d expected %0d", dists[i], l, modelo_largura(dists[i]));
      else n_pass++;
    end
  endtask

  task automatic test_latch();
    int a, l, p, oc, sa, se, sp, to;
    distancia = 9'd8;
    pulso(P_MIN + 3);
    observe(1, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (l != modelo_largura(8)) $display("FAIL latch_width: got %0d expected %0d", l, modelo_largura(8)); else n_pass++;
    n_checks++; if (p != P_PAUSA) $display("FAIL latch_pause: got %0d expected %0d", p, P_PAUSA); else n_pass++;
  endtask

  task automatic test_ignored_trigger();
    int a, l, p, oc, sa, se, sp, to;
    int viol;
    distancia = 9'd6;
    pulso(P_MIN + 1);
    observe(2, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (a != P_ATRASO) $display("FAIL busy_trigger_delay: got %0d expected %0d", a, P_ATRASO); else n_pass++;
    n_checks++; if (l != modelo_largura(6)) $display("FAIL busy_trigger_width: got %0d expected %0d", l, modelo_largura(6)); else n_pass++;
    n_checks++; if (p != P_PAUSA) $display("FAIL busy_trigger_pause: got %0d expected %0d", p, P_PAUSA); else n_pass++;
    distancia = 9'd9;
    pulso(P_MIN + 1);
    observe(3, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (l != modelo_largura(9)) $display("FAIL held_width: got %0d expected %0d", l, modelo_largura(9)); else n_pass++;
    n_checks++; if (p != P_PAUSA + 8) $display("FAIL held_pause_exit: got %0d expected %0d", p, P_PAUSA + 8); else n_pass++;
    viol = 0;
    for (int i = 0; i < P_ATRASO + 10; i++) begin
      tick();
      if (echo !== 1'b0 || ocupado !== 1'b0) viol++;
    end
    n_checks++; if (viol != 0) $display("FAIL held_trigger_ignored: got %0d busy cycles expected 0", viol); else n_pass++;
    distancia = 9'd11;
    pulso(P_MIN);
    observe(0, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (l != modelo_largura(11)) $display("FAIL after_held_width: got %0d expected %0d", l, modelo_largura(11)); else n_pass++;
  endtask

  task automatic test_random();
    int a, l, p, oc, sa, se, sp, to;
    int d, w;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 60));
      w = int'($urandom_range(P_MIN, P_MIN + 8));
      repeat ($urandom_range(0, 5)) tick();
      distancia = 9'(d);
      pulso(w);
      observe(0, a, l, p, oc, sa, se, sp, to);
      n_checks++;
      if (a != P_ATRASO || l != modelo_largura(d) || p != P_PAUSA || to != 0)
        $display("FAIL random d=%0d w=%0d: got delay/width/pause %0d/%0d/%0d expected %0d/%0d/%0d",
                 d, w, a, l, p, P_ATRASO, modelo_largura(d), P_PAUSA);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_eco();
    int a, l, p, oc, sa, se, sp, to;
    int n;
    distancia = 9'd30;
    pulso(P_MIN);
    n = 0;
    while (echo !== 1'b1 && n < LIM) begin
      tick();
      n++;
    end
    n_checks++; if (n >= LIM) $display("FAIL midreset_echo_seen: got timeout expected echo"); else n_pass++;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (echo !== 1'b0) $display("FAIL midreset_echo: got %0b expected 0", echo); else n_pass++;
    n_checks++; if (ocupado !== 1'b0) $display("FAIL midreset_ocupado: got %0b expected 0", ocupado); else n_pass++;
    n_checks++; if (db_estado !== 3'd0) $display("FAIL midreset_estado: got %0d expected 0", db_estado); else n_pass++;
    reset = 1'b0;
    tick();
    distancia = 9'd13;
    pulso(P_MIN + 1);
    observe(0, a, l, p, oc, sa, se, sp, to);
    n_checks++; if (a != P_ATRASO) $display("FAIL midreset_fresh_delay: got %0d expected %0d", a, P_ATRASO); else n_pass++;
    n_checks++; if (l != modelo_largura(13)) $display("FAIL midreset_fresh_width: got %0d expected %0d", l, modelo_largura(13)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger_width();
    test_boundaries();
    test_latch();
    test_ignored_trigger();
    test_random();
    test_reset_mid_eco();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_ultrassonico_emulador.md
Name: sensor_ultrassonico_emulador

Overview:
Synthesizable HC-SR04 responder: the sensor end of the trigger/echo interface driven by the sonar system (exp5). It watches `trigger`, validates the pulse width, waits the burst delay, then drives `echo` high for a width proportional to the distance on `distancia`. It replaces the board sensor for FPGA-in-the-loop tests; an external signal, e.g. switches, sets the distance.

Parameters:
CICLOS_TRIGGER_MIN, 500, minimum trigger high width in clock cycles (10 us at 50 MHz)
CICLOS_ATRASO, 20_000, trigger fall to echo rise (400 us)
CICLOS_POR_CM, 2941, echo cycles per cm (58.82 us)
DIST_MAX, 400, largest distance in cm that is answered normally
CICLOS_TIMEOUT, 1_900_000, echo width when out of range (38 ms)
CICLOS_PAUSA, 500_000, dead time after echo falls (10 ms)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
trigger  in  1  trigger from the measurement system, same clock domain
distancia  in  9  emulated distance in cm (0..511)
echo  out  1  echo pulse, registered
ocupado  out  1  high from valid-trigger detection until PAUSA ends
db_estado  out  3  current state encoding, for debug

Behaviour:
- Reset: echo=0, ocupado=0, db_estado=INICIAL, all counters 0. Reset in any state, including mid-echo, forces echo=0 on the next edge.
- States: INICIAL -> ESPERA_TRIGGER -> MEDE_TRIGGER -> ATRASO -> ECO -> PAUSA -> ESPERA_TRIGGER.
- INICIAL: one cycle, then ESPERA_TRIGGER.
- ESPERA_TRIGGER: trigger=1 -> MEDE_TRIGGER with the width counter at 1.
- MEDE_TRIGGER: counts cycles while trigger=1.
  - On trigger=0 with count >= CICLOS_TRIGGER_MIN: latch distancia, assert ocupado, go to ATRASO.
  - On trigger=0 with count below the minimum: go to ESPERA_TRIGGER, no echo.
  - The width counter saturates and never wraps.
- ATRASO: counts CICLOS_ATRASO cycles, then ECO. Echo's first high cycle is exactly CICLOS_ATRASO cycles after the first cycle trigger is sampled 0.
- ECO: echo=1 for exactly N cycles, then echo=0 and go to PAUSA.
  - N = max(dist_lat,1) * CICLOS_POR_CM when dist_lat <= DIST_MAX.
  - N = CICLOS_TIMEOUT when dist_lat > DIST_MAX.
  - Distance 0 is answered as 1 cm.
- Width generation: nested counters with no multiplier.
  - Sub-counter runs 0..CICLOS_POR_CM-1.
  - cm-counter runs to dist_lat.
  - Both are 22-bit max width (400*2941 = 1_176_400 and 1_900_000 < 2^22).
- Latch rule: distancia is sampled only at the MEDE_TRIGGER->ATRASO transition. Changes to distancia during ATRASO or ECO do not affect the current pulse.
- PAUSA: counts CICLOS_PAUSA cycles with ocupado=1, echo=0.
  - Then go to ESPERA_TRIGGER only if trigger=0; otherwise wait for trigger=0 first.
  - A trigger already high at the exit is never measured mid-pulse.
- Trigger activity in ATRASO, ECO or PAUSA is ignored: no restart, no extension.
- ocupado drops in the cycle the FSM enters ESPERA_TRIGGER.

Decomposition:
- Shared package (sonar_pkg):
  - state encodings: INICIAL=0, ESPERA_TRIGGER=1, MEDE_TRIGGER=2, ATRASO=3, ECO=4, PAUSA=5
  - default timing constants: CICLOS_POR_CM, CICLOS_ATRASO, CICLOS_TIMEOUT, shared with the sonar measurement side
- Split: FSM (sensor_ultrassonico_uc) plus datapath.
- Datapath reuses the team's generic mod-M counter, contador_m, for the delay, sub-cm, and pause counters. The cm-counter and the latch register are local.

Test Plan:
- distancia=100, 10 us trigger -> echo rises 20_000 cycles after trigger falls and is high 294_100 cycles (5882 us); ocupado falls 500_000 cycles after echo falls.
- distancia=74 -> echo 217_634 cycles (~4353 us); distancia changed to 300 during ECO -> width unchanged.
- 5 us trigger (250 cycles) -> no echo and ocupado stays 0; a following 10 us trigger is answered normally.
- distancia=450 -> echo 1_900_000 cycles; distancia=0 -> echo 2941 cycles.
- Second trigger pulse during ECO and another held high across PAUSA exit -> neither restarts echo; the held trigger is ignored until it goes low, then the next valid pulse is answered.
- reset asserted mid-ECO -> echo=0, ocupado=0, db_estado=INICIAL on the next edge; a fresh trigger afterwards gives a correct pulse.
